// File: rtl/mem_arb_pkg.sv
// Shared types and the slot ownership map for mem_slot_arbiter.
// Optional feature macro: MEM_ARB_DMA_SLOT_EN (defined -> slot 2 belongs to dma, else to cpu).
// Pure declarations, no logic.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  typedef enum logic [1:0] {
    REQ_CPU,
    REQ_VID,
    REQ_DMA,
    REQ_NONE
  } req_id_e;

  // Slot 0 is the frame_sync slot and always feeds the video refresh.
  localparam req_id_e SLOT0_OWNER = REQ_VID;
  localparam req_id_e SLOT1_OWNER = REQ_CPU;
`ifdef MEM_ARB_DMA_SLOT_EN
  localparam req_id_e SLOT2_OWNER = REQ_DMA;
`else
  localparam req_id_e SLOT2_OWNER = REQ_CPU;
`endif
  localparam req_id_e SLOT3_OWNER = REQ_CPU;

  function automatic req_id_e slot_owner(input logic [1:0] slot);
    case (slot)
      2'd0:    return SLOT0_OWNER;
      2'd1:    return SLOT1_OWNER;
      2'd2:    return SLOT2_OWNER;
      default: return SLOT3_OWNER;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for one memory slot: slot owner first, then cpu > dma > vid.
// Latency: purely combinational.
// Backpressure: none; caller masks requests it must not grant.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] slot,
  input  logic       cpu_req,
  input  logic       vid_req,
  input  logic       dma_req,
  output req_id_e    winner
);

  req_id_e owner;
  logic    owner_req;

  // Owner of the slot wins if it asks; otherwise fixed priority fallback.
  always_comb begin
    owner     = slot_owner(slot);
    owner_req = 1'b0;
    case (owner)
      REQ_CPU: owner_req = cpu_req;
      REQ_VID: owner_req = vid_req;
      REQ_DMA: owner_req = dma_req;
      default: owner_req = 1'b0;
    endcase
    winner = REQ_NONE;
    if (owner_req)    winner = owner;
    else if (cpu_req) winner = REQ_CPU;
    else if (dma_req) winner = REQ_DMA;
    else if (vid_req) winner = REQ_VID;
  end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Time-slotted arbiter sharing one 8-bit memory port between cpu, vid and dma.
// Latency: mem_req 1 clk after the granting slot_ce; X_ack 1 clk after mem_ready or timeout.
// Backpressure: requests are levels held until X_ack; cpu_wait stalls the cpu meanwhile.
// Optional feature macro MEM_ARB_DMA_SLOT_EN selects the owner of slot 2 (see mem_arb_pkg).
module mem_slot_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slot_ce,
  input  logic              frame_sync,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_we,
  input  logic [7:0]        vid_wdata,
  output logic              vid_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        rdata,
  output logic              cpu_wait,
  output logic              tmo_err
);

  // Timeout fires on the TMO_CYC-th consecutive WAIT clock without mem_ready.
  localparam logic [3:0] TMO_LAST = 4'(TMO_CYC - 1);

  state_e            state;
  req_id_e           cur_id;
  req_id_e           win_id;
  logic [1:0]        slot_cnt;
  logic [1:0]        cur_slot;
  logic [3:0]        tmo_cnt;
  logic              grant;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic [7:0]        win_wdata;

  // A frame_sync strobe marks slot 0 regardless of where the counter drifted.
  assign cur_slot = frame_sync ? 2'd0 : slot_cnt;
  assign cpu_wait = cpu_req & ~cpu_ack;

  // Slot counter advances on every slot_ce, granted or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        slot_cnt <= 2'd0;
    else if (slot_ce) slot_cnt <= cur_slot + 2'd1;
  end

  // A requester being acked this clock is not eligible again in the same clock.
  mem_arb_pick u_pick (
    .slot    (cur_slot),
    .cpu_req (cpu_req & ~cpu_ack),
    .vid_req (vid_req & ~vid_ack),
    .dma_req (dma_req & ~dma_ack),
    .winner  (win_id)
  );

  assign grant = slot_ce && (state == S_IDLE) && (win_id != REQ_NONE);

  // Route the winning requester's command onto the capture path.
  always_comb begin
    win_addr  = cpu_addr;
    win_we    = cpu_we;
    win_wdata = cpu_wdata;
    case (win_id)
      REQ_VID: begin
        win_addr  = vid_addr;
        win_we    = vid_we;
        win_wdata = vid_wdata;
      end
      REQ_DMA: begin
        win_addr  = dma_addr;
        win_we    = dma_we;
        win_wdata = dma_wdata;
      end
      default: begin
      end
    endcase
  end

  // Access FSM: capture command at grant, one-clk mem_req, then wait for ready or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_id    <= REQ_NONE;
      tmo_cnt   <= 4'd0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      rdata     <= 8'hFF;
      tmo_err   <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            state     <= S_ISSUE;
            cur_id    <= win_id;
            mem_req   <= 1'b1;
            mem_addr  <= win_addr;
            mem_we    <= win_we;
            mem_wdata <= win_wdata;
          end
        end
        S_ISSUE: begin
          state   <= S_WAIT;
          tmo_cnt <= 4'd0;
        end
        S_WAIT: begin
          if (mem_ready || (tmo_cnt == TMO_LAST)) begin
            state   <= S_IDLE;
            cpu_ack <= (cur_id == REQ_CPU);
            vid_ack <= (cur_id == REQ_VID);
            dma_ack <= (cur_id == REQ_DMA);
            if (!mem_we) rdata <= mem_ready ? mem_rdata : 8'hFF;
            if (!mem_ready) tmo_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
